// File: rtl/and_vec_seq.sv
// Exhaustive stimulus sequencer for a 3-input AND gate: sweeps all 8 vectors and captures y_in.
// Optional AND_SELFCHECK_EN adds err_cnt/pass against an ideal AND.
module and_vec_seq #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
`ifdef AND_SELFCHECK_EN
  output logic [3:0] err_cnt,
  output logic       pass,
`endif
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec_idx,
  output logic [7:0] truth
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [3:0] DwellLast = 4'(DWELL - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] truth_q, truth_d;
  logic [2:0] abc_q, abc_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    truth_d = truth_q;
    abc_d   = abc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          vec_d   = 3'd0;
          dwell_d = 4'd0;
          truth_d = 8'h00;
          abc_d   = 3'b000;
        end
      end
      StDrive: begin
        dwell_d = dwell_q + 4'd1;
        if (dwell_q == DwellLast) begin
          dwell_d          = 4'd0;
          truth_d[vec_q]   = y_in;
          // Vector 7 is the last one; vec_idx parks there instead of wrapping.
          if (vec_q == 3'd7) begin
            state_d = StDone;
            abc_d   = 3'b000;
          end else begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      dwell_q <= 4'd0;
      truth_q <= 8'h00;
      abc_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      truth_q <= truth_d;
      abc_q   <= abc_d;
    end
  end

  assign a       = abc_q[2];
  assign b       = abc_q[1];
  assign c       = abc_q[0];
  assign busy    = (state_q == StDrive);
  assign done    = (state_q == StDone);
  assign vec_idx = vec_q;
  assign truth   = truth_q;

`ifdef AND_SELFCHECK_EN
  logic [3:0] err_q, err_d;
  logic       capture;
  logic       accept;

  assign accept  = (state_q == StIdle) && start;
  assign capture = (state_q == StDrive) && (dwell_q == DwellLast);

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 4'd0;
    end else if (capture && (y_in != (&vec_q))) begin
      err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 4'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
  assign pass    = done && (err_q == 4'd0);
`endif

endmodule

// File: tb/tb_and_vec_seq.sv
// Randomised bench for and_vec_seq: two instances (DWELL=4 and DWELL=1) driven by a LUT gate model.
module tb_and_vec_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  bit         sel;
  logic [7:0] lut;

  always #5 clk = ~clk;

  logic       start4, start1, y4, y1;
  logic       a4, b4, c4, busy4, done4;
  logic       a1, b1, c1, busy1, done1;
  logic [2:0] vec4, vec1;
  logic [7:0] truth4, truth1;
`ifdef AND_SELFCHECK_EN
  logic [3:0] err4, err1;
  logic       pass4, pass1;
`endif

  assign start4 = sel ? 1'b0 : start;
  assign start1 = sel ? start : 1'b0;
  assign y4     = lut[{a4, b4, c4}];
  assign y1     = lut[{a1, b1, c1}];

  and_vec_seq #(.DWELL(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .y_in    (y4),
`ifdef AND_SELFCHECK_EN
    .err_cnt (err4),
    .pass    (pass4),
`endif
    .a       (a4),
    .b       (b4),
    .c       (c4),
    .busy    (busy4),
    .done    (done4),
    .vec_idx (vec4),
    .truth   (truth4)
  );

  and_vec_seq #(.DWELL(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .y_in    (y1),
`ifdef AND_SELFCHECK_EN
    .err_cnt (err1),
    .pass    (pass1),
`endif
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .busy    (busy1),
    .done    (done1),
    .vec_idx (vec1),
    .truth   (truth1)
  );

  // Observed view of the selected instance
  logic [2:0] o_abc, o_vec;
  logic       o_busy, o_done;
  logic [7:0] o_truth;
  always_comb begin
    o_abc   = sel ? {a1, b1, c1} : {a4, b4, c4};
    o_vec   = sel ? vec1 : vec4;
    o_busy  = sel ? busy1 : busy4;
    o_done  = sel ? done1 : done4;
    o_truth = sel ? truth1 : truth4;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs n cycles after the accepting edge, derived from sweep arithmetic.
  task automatic check_cycle(input int n, input int d);
    int         v, caps;
    logic [8:0] mask9;
    logic [7:0] mask;
    logic       e_busy, e_done;
    logic [2:0] e_abc, e_vec;
    if (n <= 8 * d) begin
      v = (n - 1) / d; caps = v;
      e_busy = 1'b1; e_done = 1'b0; e_abc = 3'(v); e_vec = 3'(v);
    end else begin
      caps = 8;
      e_busy = 1'b0; e_done = (n == 8 * d + 1); e_abc = 3'd0; e_vec = 3'd7;
    end
    mask9 = (9'd1 << caps) - 9'd1;
    mask  = mask9[7:0];
    check_eq("busy", 32'(o_busy), 32'(e_busy));
    check_eq("done", 32'(o_done), 32'(e_done));
    check_eq("abc", 32'(o_abc), 32'(e_abc));
    check_eq("vec_idx", 32'(o_vec), 32'(e_vec));
    check_eq("truth", 32'(o_truth), 32'(lut & mask));
`ifdef AND_SELFCHECK_EN
    begin
      int         e_err;
      logic [3:0] g_err;
      logic       g_pass;
      e_err  = $countones((lut ^ 8'h80) & mask);
      g_err  = sel ? err1 : err4;
      g_pass = sel ? pass1 : pass4;
      check_eq("err_cnt", 32'(g_err), 32'(e_err));
      check_eq("pass", 32'(g_pass), 32'(e_done && (e_err == 0)));
    end
`endif
  endtask

  // Called at a negedge. p = cycle of an extra (ignored) start pulse, 0 for none.
  task automatic sweep(input bit s, input logic [7:0] l, input int p, input bit hold);
    int d;
    sel   = s;
    lut   = l;
    d     = s ? 1 : 4;
    start = 1'b1;
    for (int n = 1; n <= 8 * d + 2; n++) begin
      @(negedge clk);
      if (!hold) begin
        if (n == p) start = 1'b1;
        else        start = 1'b0;
      end
      check_cycle(n, d);
    end
  endtask

  task automatic idle_cycles(input int k, input logic [2:0] e_vec);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(o_busy), 32'd0);
      check_eq("idle_vec", 32'(o_vec), 32'(e_vec));
    end
  endtask

  task automatic reset_mid();
    sel   = 1'b0;
    lut   = 8'h5F;
    start = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle(n, 4);
    end
    check_eq("rst_pre_vec", 32'(o_vec), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("rst_abc", 32'(o_abc), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_vec", 32'(o_vec), 32'd0);
    check_eq("rst_truth", 32'(o_truth), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_busy", 32'(o_busy), 32'd0);
      check_eq("post_rst_vec", 32'(o_vec), 32'd0);
      check_eq("post_rst_truth", 32'(o_truth), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    lut   = 8'h80;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      check_eq("reset_abc", 32'(o_abc), 32'd0);
      check_eq("reset_busy", 32'(o_busy), 32'd0);
      check_eq("reset_done", 32'(o_done), 32'd0);
      check_eq("reset_vec", 32'(o_vec), 32'd0);
      check_eq("reset_truth", 32'(o_truth), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b0;
    idle_cycles(2, 3'd0);

    sweep(1'b0, 8'h80, 0, 1'b0);             // ideal gate
    sweep(1'b0, 8'hFF, 0, 1'b0);             // y_in tied high
    sweep(1'b0, 8'h80, 9, 1'b0);             // re-start while vec_idx=2
    reset_mid();
    sweep(1'b1, 8'h80, 0, 1'b0);             // DWELL=1
    idle_cycles(1, 3'd7);
    sweep(1'b0, 8'h80, 0, 1'b1);             // start held across two sweeps
    sweep(1'b0, 8'h80, 0, 1'b0);
    idle_cycles(1, 3'd7);
    sweep(1'b0, 8'h80, 33, 1'b0);            // start during the done cycle
    idle_cycles(2, 3'd7);

    for (int i = 0; i < 8; i++) begin
      bit         s;
      logic [7:0] l;
      int         d, p;
      s = bit'($urandom_range(0, 1));
      l = 8'($urandom);
      d = s ? 1 : 4;
      p = $urandom_range(0, 8 * d + 1);
      sel = s;
      idle_cycles($urandom_range(0, 3), sel ? vec1 : vec4);
      sweep(s, l, p, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule
